granule_scheduler: RTL and testbench



---
 rtl/granule_scheduler.sv | 154 +++++++++++++++
 tb/tb_granule_scheduler.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/granule_scheduler.sv
// Frame-level controller for the two granule pipelines and the granule assembler.
// Admits one frame, launches both granules, counts their samples and the 1152-sample readout.
module granule_scheduler #(
  parameter int SAMPLES_PER_GR = 576,
  parameter int STAGGER        = 0,
  parameter int TIMEOUT        = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_ready_in,
  input  logic        sink_ready_in,
  input  logic        gr1_valid_in,
  input  logic        gr2_valid_in,
  input  logic        asm_valid_in,
  input  logic        clear_err_in,
  output logic        frame_ack_out,
  output logic        new_frame_start_out,
  output logic        gr1_start_out,
  output logic        gr2_start_out,
  output logic        busy_out,
  output logic        frame_done_out,
  output logic        error_out,
  output logic [2:0]  state_out,
  output logic [15:0] frames_done_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [9:0]  GR_FULL   = 10'(SAMPLES_PER_GR);
  localparam logic [10:0] ASM_FULL  = 11'(2 * SAMPLES_PER_GR);
  localparam logic [15:0] STAGGER_W = 16'(STAGGER);
  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  logic [2:0]  state_reg, state_next;
  logic [9:0]  gr1_cnt_reg, gr1_cnt_next;
  logic [9:0]  gr2_cnt_reg, gr2_cnt_next;
  logic [10:0] asm_cnt_reg, asm_cnt_next;
  logic [15:0] launch_cnt_reg, launch_cnt_next;
  logic [15:0] wd_reg, wd_next;
  logic [15:0] frames_reg, frames_next;
  logic        go_err;
  logic        progress;

  always_comb begin
    state_next      = state_reg;
    gr1_cnt_next    = gr1_cnt_reg;
    gr2_cnt_next    = gr2_cnt_reg;
    asm_cnt_next    = asm_cnt_reg;
    launch_cnt_next = launch_cnt_reg;
    frames_next     = frames_reg;
    wd_next         = '0;
    go_err          = 1'b0;
    progress        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (frame_ready_in && sink_ready_in) state_next = S_START;
      end
      S_START: begin
        gr1_cnt_next    = '0;
        gr2_cnt_next    = '0;
        asm_cnt_next    = '0;
        launch_cnt_next = '0;
        state_next      = S_LAUNCH;
      end
      S_LAUNCH, S_FILL: begin
        progress = gr1_valid_in || gr2_valid_in;
        if (gr1_valid_in) begin
          if (gr1_cnt_reg == GR_FULL) go_err = 1'b1;
          else gr1_cnt_next = gr1_cnt_reg + 10'd1;
        end
        if (gr2_valid_in) begin
          if (gr2_cnt_reg == GR_FULL) go_err = 1'b1;
          else gr2_cnt_next = gr2_cnt_reg + 10'd1;
        end
        if (asm_valid_in) go_err = 1'b1;
        // gr2 launch pulse fires when launch_cnt reaches STAGGER; leave one cycle later
        if (state_reg == S_LAUNCH) begin
          if (launch_cnt_reg == STAGGER_W) state_next = S_FILL;
          else launch_cnt_next = launch_cnt_reg + 16'd1;
        end else if (gr1_cnt_next == GR_FULL && gr2_cnt_next == GR_FULL) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (gr1_valid_in || gr2_valid_in) go_err = 1'b1;
        if (asm_valid_in) begin
          progress     = 1'b1;
          asm_cnt_next = asm_cnt_reg + 11'd1;
          if (asm_cnt_reg == ASM_FULL - 11'd1) state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR: begin
        if (clear_err_in) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase

    // Watchdog only advances while an active state is stuck without progress
    if ((state_reg == S_LAUNCH || state_reg == S_FILL || state_reg == S_DRAIN) &&
        state_next == state_reg && !progress) begin
      wd_next = wd_reg + 16'd1;
      if (wd_next == TIMEOUT_W) go_err = 1'b1;
    end

    if (go_err) state_next = S_ERR;
    if (state_reg == S_DRAIN && state_next == S_DONE) frames_next = frames_reg + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg           <= S_IDLE;
      gr1_cnt_reg         <= '0;
      gr2_cnt_reg         <= '0;
      asm_cnt_reg         <= '0;
      launch_cnt_reg      <= '0;
      wd_reg              <= '0;
      frames_reg          <= '0;
      frame_ack_out       <= 1'b0;
      new_frame_start_out <= 1'b0;
      gr1_start_out       <= 1'b0;
      gr2_start_out       <= 1'b0;
      busy_out            <= 1'b0;
      frame_done_out      <= 1'b0;
      error_out           <= 1'b0;
    end else begin
      state_reg           <= state_next;
      gr1_cnt_reg         <= gr1_cnt_next;
      gr2_cnt_reg         <= gr2_cnt_next;
      asm_cnt_reg         <= asm_cnt_next;
      launch_cnt_reg      <= launch_cnt_next;
      wd_reg              <= wd_next;
      frames_reg          <= frames_next;
      frame_ack_out       <= (state_next == S_START);
      new_frame_start_out <= (state_next == S_START);
      gr1_start_out       <= (state_reg == S_START) && (state_next == S_LAUNCH);
      gr2_start_out       <= (state_next == S_LAUNCH) && (launch_cnt_next == STAGGER_W);
      busy_out            <= (state_next != S_IDLE);
      frame_done_out      <= (state_next == S_DONE);
      error_out           <= (state_next == S_ERR);
    end
  end

  assign state_out       = state_reg;
  assign frames_done_out = frames_reg;

endmodule

// File: tb/tb_granule_scheduler.sv
// Bench for granule_scheduler: two instances (STAGGER=0/TIMEOUT=65535 and STAGGER=3/TIMEOUT=100)
// share randomized stimulus and are compared every cycle against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_granule_scheduler;
  localparam int SPG = 576;

  logic clk = 1'b0;
  logic rst, frame_ready, sink_ready, v1, v2, av, clr;
  logic ack [2], nfs [2], g1s [2], g2s [2], busy [2], done [2], err [2];
  logic [2:0]  st  [2];
  logic [15:0] fdo [2];

  int total = 0;
  int bad   = 0;
  int n     = 0;
  int s1, s2, sa, last_v;
  int m_ph [2], m_g1 [2], m_g2 [2], m_a [2], m_fd [2], m_la [2], m_lp [2];
  logic [6:0] m_flags [2];

  always #5 clk = ~clk;

  granule_scheduler #(.SAMPLES_PER_GR(SPG), .STAGGER(0), .TIMEOUT(65535)) dut0 (
    .clk(clk), .rst(rst), .frame_ready_in(frame_ready), .sink_ready_in(sink_ready),
    .gr1_valid_in(v1), .gr2_valid_in(v2), .asm_valid_in(av), .clear_err_in(clr),
    .frame_ack_out(ack[0]), .new_frame_start_out(nfs[0]), .gr1_start_out(g1s[0]),
    .gr2_start_out(g2s[0]), .busy_out(busy[0]), .frame_done_out(done[0]),
    .error_out(err[0]), .state_out(st[0]), .frames_done_out(fdo[0]));

  granule_scheduler #(.SAMPLES_PER_GR(SPG), .STAGGER(3), .TIMEOUT(100)) dut1 (
    .clk(clk), .rst(rst), .frame_ready_in(frame_ready), .sink_ready_in(sink_ready),
    .gr1_valid_in(v1), .gr2_valid_in(v2), .asm_valid_in(av), .clear_err_in(clr),
    .frame_ack_out(ack[1]), .new_frame_start_out(nfs[1]), .gr1_start_out(g1s[1]),
    .gr2_start_out(g2s[1]), .busy_out(busy[1]), .frame_done_out(done[1]),
    .error_out(err[1]), .state_out(st[1]), .frames_done_out(fdo[1]));

  function automatic int st_of(input int i);
    return (i == 0) ? 0 : 3;
  endfunction

  function automatic int to_of(input int i);
    return (i == 0) ? 65535 : 100;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp_v, n);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ph[i] = 0; m_g1[i] = 0; m_g2[i] = 0; m_a[i] = 0;
      m_fd[i] = 0; m_la[i] = 0; m_lp[i] = 0; m_flags[i] = '0;
    end
  endtask

  // Phase model driven by edge timestamps: launch edge and last-progress edge
  task automatic model_step(input int i);
    int  ph;
    int  nph;
    bit  fault;
    ph    = m_ph[i];
    nph   = ph;
    fault = 0;
    case (ph)
      0: if (frame_ready && sink_ready) nph = 1;
      1: begin
        m_g1[i] = 0; m_g2[i] = 0; m_a[i] = 0; m_la[i] = n; nph = 2;
      end
      2, 3: begin
        if (v1) begin if (m_g1[i] == SPG) fault = 1; else m_g1[i]++; end
        if (v2) begin if (m_g2[i] == SPG) fault = 1; else m_g2[i]++; end
        if (av) fault = 1;
        if (v1 || v2) m_lp[i] = n;
        if (ph == 2) begin
          if (n == m_la[i] + st_of(i) + 1) nph = 3;
        end else if (m_g1[i] == SPG && m_g2[i] == SPG) begin
          nph = 4;
        end
      end
      4: begin
        if (v1 || v2) fault = 1;
        if (av) begin
          m_a[i]++;
          m_lp[i] = n;
          if (m_a[i] == 2 * SPG) nph = 5;
        end
      end
      5: nph = 0;
      6: if (clr) nph = 0;
      default: nph = 0;
    endcase
    if ((ph == 2 || ph == 3 || ph == 4) && nph == ph && (n - m_lp[i]) == to_of(i)) fault = 1;
    if (fault) nph = 6;
    if (ph == 4 && nph == 5) m_fd[i] = (m_fd[i] + 1) % 65536;
    m_flags[i] = {nph == 1, nph == 1, (ph == 1 && nph == 2),
                  (nph == 2 && n == m_la[i] + st_of(i)), nph != 0, nph == 5, nph == 6};
    if (nph != ph) m_lp[i] = n;
    m_ph[i] = nph;
  endtask

  task automatic tick();
    @(posedge clk);
    n++;
    for (int i = 0; i < 2; i++) model_step(i);
    #1;
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("state[%0d]", i), 32'(st[i]), 32'(m_ph[i]));
      check_val($sformatf("pulses[%0d]", i),
                32'({ack[i], nfs[i], g1s[i], g2s[i], busy[i], done[i], err[i]}), 32'(m_flags[i]));
      check_val($sformatf("frames[%0d]", i), 32'(fdo[i]), 32'(m_fd[i]));
    end
  endtask

  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      check_val($sformatf("rst_state[%0d]", i), 32'(st[i]), 32'd0);
      check_val($sformatf("rst_pulses[%0d]", i),
                32'({ack[i], nfs[i], g1s[i], g2s[i], busy[i], done[i], err[i]}), 32'd0);
      check_val($sformatf("rst_frames[%0d]", i), 32'(fdo[i]), 32'd0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic gr_tick(input int n1, input int n2);
    v1 = (s1 < n1) && ($urandom_range(0, 3) != 0);
    v2 = (s2 < n2) && ($urandom_range(0, 99) < 65);
    av = 1'b0;
    frame_ready = 1'($urandom_range(0, 1));
    sink_ready  = 1'($urandom_range(0, 1));
    tick();
    if (v1) s1++;
    if (v2) s2++;
    if (v1 || v2) last_v = n;
  endtask

  task automatic admit();
    frame_ready = 1'b1; sink_ready = 1'b1; v1 = 1'b0; v2 = 1'b0; av = 1'b0;
    tick();
    check_val("start_state", 32'(st[0]), 32'd1);
    check_val("new_frame_start", 32'(nfs[0]), 32'd1);
    check_val("frame_ack", 32'(ack[0]), 32'd1);
    frame_ready = 1'b0; sink_ready = 1'b0;
  endtask

  task automatic launch();
    s1 = 0; s2 = 0;
    tick();
    check_val("gr1_start0", 32'(g1s[0]), 32'd1);
    check_val("gr2_start0_same", 32'(g2s[0]), 32'd1);
    check_val("gr1_start1", 32'(g1s[1]), 32'd1);
    check_val("gr2_start1_early", 32'(g2s[1]), 32'd0);
    gr_tick(SPG, SPG);
    check_val("fill_entry0", 32'(st[0]), 32'd3);
    gr_tick(SPG, SPG);
    gr_tick(SPG, SPG);
    check_val("gr2_start1_stagger", 32'(g2s[1]), 32'd1);
    check_val("launch_hold1", 32'(st[1]), 32'd2);
  endtask

  task automatic fill(input int n1, input int n2);
    int c;
    c = 0;
    while ((s1 < n1 || s2 < n2) && c < 4000) begin
      gr_tick(n1, n2);
      c++;
    end
    if (s1 < n1 || s2 < n2) check_val("fill_budget", 32'(s1 + s2), 32'(n1 + n2));
    v1 = 1'b0; v2 = 1'b0; frame_ready = 1'b0; sink_ready = 1'b0;
  endtask

  task automatic drain(input int limit);
    int c;
    c = 0; sa = 0;
    frame_ready = 1'b0; sink_ready = 1'b0;
    while (sa < limit && c < 6000) begin
      av = 1'($urandom_range(0, 1));
      tick();
      if (av) sa++;
      c++;
    end
    av = 1'b0;
    if (sa < limit) check_val("drain_budget", 32'(sa), 32'(limit));
  endtask

  task automatic full_frame(input int expect_frames);
    fill(SPG, SPG);
    check_val("drain_entry0", 32'(st[0]), 32'd4);
    check_val("drain_entry1", 32'(st[1]), 32'd4);
    drain(2 * SPG);
    check_val("frame_done0", 32'(done[0]), 32'd1);
    check_val("frame_done1", 32'(done[1]), 32'd1);
    check_val("frames_count", 32'(fdo[0]), 32'(expect_frames));
    tick();
    check_val("back_idle", 32'(st[0]), 32'd0);
    $display("frame complete: frames_done=%0d edge=%0d", fdo[0], n);
  endtask

  initial begin
    int acks;
    int c;
    rst = 1'b0; frame_ready = 1'b0; sink_ready = 1'b0;
    v1 = 1'b0; v2 = 1'b0; av = 1'b0; clr = 1'b0;
    last_v = 0; s1 = 0; s2 = 0; sa = 0;
    model_reset();
    do_reset();

    // Valids while idle are ignored
    for (int k = 0; k < 20; k++) begin
      v1 = 1'($urandom_range(0, 1)); v2 = 1'($urandom_range(0, 1)); av = 1'($urandom_range(0, 1));
      sink_ready = 1'($urandom_range(0, 1)); frame_ready = 1'b0;
      tick();
    end
    v1 = 1'b0; v2 = 1'b0; av = 1'b0; sink_ready = 1'b0;
    check_val("idle_noise", 32'(st[0]), 32'd0);

    admit(); launch(); full_frame(1);
    admit(); launch(); full_frame(2);

    // Overflow: one gr1 valid beyond a full granule while gr2 is still filling
    admit(); launch(); fill(SPG, 500);
    check_val("ovf_pre_fill", 32'(st[0]), 32'd3);
    v1 = 1'b1;
    tick();
    v1 = 1'b0;
    check_val("ovf_err_state", 32'(st[0]), 32'd6);
    check_val("ovf_err_out", 32'(err[0]), 32'd1);
    check_val("ovf_no_done", 32'(done[0]), 32'd0);
    for (int k = 0; k < 5; k++) begin
      v1 = 1'($urandom_range(0, 1)); v2 = 1'($urandom_range(0, 1)); av = 1'($urandom_range(0, 1));
      tick();
    end
    v1 = 1'b0; v2 = 1'b0; av = 1'b0;
    check_val("err_sticky", 32'(err[0]), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_val("clr_idle", 32'(st[0]), 32'd0);
    check_val("clr_err_out", 32'(err[0]), 32'd0);
    $display("overflow handled: edge=%0d", n);

    // Timeout: gr2 stalls at 575 samples
    admit(); launch(); fill(SPG, SPG - 1);
    c = 0;
    while (st[1] != 3'd6 && c < 300) begin
      tick();
      c++;
    end
    check_val("timeout_gap", 32'(n - last_v), 32'd100);
    check_val("timeout_err", 32'(err[1]), 32'd1);
    check_val("no_timeout_long", 32'(st[0]), 32'd3);
    $display("timeout seen: gap=%0d", n - last_v);
    do_reset();

    // Backpressure from the sink
    frame_ready = 1'b1; sink_ready = 1'b0; acks = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (ack[0]) acks++;
    end
    check_val("bp_no_ack", 32'(acks), 32'd0);
    check_val("bp_idle", 32'(st[0]), 32'd0);
    sink_ready = 1'b1;
    tick();
    check_val("bp_start", 32'(st[0]), 32'd1);
    frame_ready = 1'b0; sink_ready = 1'b0;
    launch(); fill(SPG, SPG); drain(600);
    check_val("mid_drain", 32'(st[0]), 32'd4);
    $display("reset mid-drain after %0d asm valids", sa);
    do_reset();

    admit(); launch(); full_frame(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish, total=%0d", total);
    $fatal(1);
  end

endmodule
